// File: rtl/pwm_dimmer_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dimmer_mc_pkg
// Description : Shared defaults, ramp-direction type and duty helpers for the
//               multi-channel PWM dimmer.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_dimmer_mc_pkg;

    localparam int c_DEFAULT_W  = 4;
    localparam int c_DEFAULT_CH = 4;
    localparam int c_DEFAULT_PW = 8;
    localparam int c_DEFAULT_SW = 2;

    // Breathe ramp direction; reset value is DIR_UP.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } ramp_dir_e;

    // Full-scale duty (constant high) for a W-bit counter.
    function automatic int duty_max(input int w);
        return 1 << w;
    endfunction

endpackage : pwm_dimmer_mc_pkg
`default_nettype wire

// File: rtl/pwm_dimmer_mc_ch.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dimmer_mc_ch
// Description : One dimmer channel: shadow/active duty double buffer, breathe
//               ramp with edge detection, and the registered PWM comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_dimmer_mc_ch
    import pwm_dimmer_mc_pkg::*;
#(
    parameter int W = c_DEFAULT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         boundary,
    input  logic [W-1:0] cnt,
    input  logic         wr,
    input  logic [W:0]   wr_data,
    input  logic         breathe,
    output logic         pwm
);

    localparam logic [W:0] c_DUTY_MAX = (W+1)'(duty_max(W));

    logic [W:0]  shadow_q,  shadow_d;
    logic [W:0]  active_q,  active_d;
    ramp_dir_e   dir_q,     dir_d;
    logic        breathe_q, breathe_d;
    logic        pwm_q,     pwm_d;
    logic        w_rise;
    ramp_dir_e   w_dir_eff;

    // Next-state: shadow capture, boundary load or ramp step, output compare.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        breathe_d = breathe_q;
        w_rise    = 1'b0;
        w_dir_eff = dir_q;

        if (wr) begin
            shadow_d = wr_data;
        end

        // Edge register only advances while running so a freeze holds dir too.
        if (enable) begin
            breathe_d = breathe;
            w_rise    = breathe & ~breathe_q;
        end

        // On entering breathe, pick a direction that keeps the ramp in range.
        if (w_rise) begin
            if (active_q == c_DUTY_MAX) begin
                w_dir_eff = DIR_DOWN;
            end else if (active_q == '0) begin
                w_dir_eff = DIR_UP;
            end
        end
        dir_d = w_dir_eff;

        if (boundary) begin
            if (breathe) begin
                if (w_dir_eff == DIR_UP) begin
                    if (active_q != c_DUTY_MAX) begin
                        active_d = active_q + 1'b1;
                    end
                end else begin
                    if (active_q != '0) begin
                        active_d = active_q - 1'b1;
                    end
                end
                if (active_d == c_DUTY_MAX) begin
                    dir_d = DIR_DOWN;
                end else if (active_d == '0) begin
                    dir_d = DIR_UP;
                end
            end else begin
                // shadow_d already folds in a same-cycle write.
                active_d = shadow_d;
            end
        end

        // W+1-bit compare so full scale stays high across the whole period.
        pwm_d = enable & ({1'b0, cnt} < active_q);
    end

    // Channel state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            dir_q     <= DIR_UP;
            breathe_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            dir_q     <= dir_d;
            breathe_q <= breathe_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule : pwm_dimmer_mc_ch
`default_nettype wire

// File: rtl/pwm_dimmer_mc.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dimmer_mc
// Description : Multi-channel PWM LED dimmer with prescaler, double-buffered
//               duty registers, true 0 %/100 % duty and per-channel breathe.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_dimmer_mc
    import pwm_dimmer_mc_pkg::*;
#(
    parameter int W  = c_DEFAULT_W,
    parameter int CH = c_DEFAULT_CH,
    parameter int PW = c_DEFAULT_PW,
    parameter int SW = c_DEFAULT_SW   // must cover clog2(CH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [PW-1:0] presc,
    input  logic          duty_wr,
    input  logic [SW-1:0] duty_sel,
    input  logic [W:0]    duty_in,
    input  logic [CH-1:0] breathe,
    output logic [CH-1:0] pwm,
    output logic          period_start
);

    localparam logic [W:0] c_DUTY_MAX = (W+1)'(duty_max(W));

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [W-1:0]  cnt_q,  cnt_d;
    logic          period_start_q, period_start_d;
    logic          w_tick;
    logic          w_boundary;
    logic [W:0]    w_duty_sat;
    logic [CH-1:0] w_wr_ch;

    // Prescaler, phase counter and period-boundary detection.
    always_comb begin
        w_tick     = enable & (pcnt_q == presc);
        w_boundary = w_tick & (cnt_q == {W{1'b1}});

        pcnt_d = pcnt_q;
        if (w_tick) begin
            pcnt_d = '0;
        end else if (enable) begin
            pcnt_d = pcnt_q + 1'b1;
        end

        cnt_d = cnt_q;
        if (w_tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        period_start_d = w_boundary;
        w_duty_sat     = (duty_in > c_DUTY_MAX) ? c_DUTY_MAX : duty_in;
    end

    // Shared timebase registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q         <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    // Selects >= CH match no channel, so such writes fall on the floor.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign w_wr_ch[i] = duty_wr & (duty_sel == SW'(i));

        pwm_dimmer_mc_ch #(
            .W (W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable),
            .boundary (w_boundary),
            .cnt      (cnt_q),
            .wr       (w_wr_ch[i]),
            .wr_data  (w_duty_sat),
            .breathe  (breathe[i]),
            .pwm      (pwm[i])
        );
    end

endmodule : pwm_dimmer_mc
`default_nettype wire
